// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared definitions for the intersection phase sequencer.
//   - Phase codes PH_NS_G..PH_WALK and the matching phase_t state enum.
//   - Light-head encodings {R,Y,G} one-hot: LT_R, LT_Y, LT_G.
//   - next_phase(): the normal six-phase successor of a phase.
//   The pedestrian WALK phase only exists in builds with TRAFFIC_PED_EN defined.
package traffic_pkg;

    localparam logic [2:0] PH_NS_G = 3'd0;
    localparam logic [2:0] PH_NS_Y = 3'd1;
    localparam logic [2:0] PH_AR1  = 3'd2;
    localparam logic [2:0] PH_EW_G = 3'd3;
    localparam logic [2:0] PH_EW_Y = 3'd4;
    localparam logic [2:0] PH_AR2  = 3'd5;
    localparam logic [2:0] PH_WALK = 3'd6;

    localparam logic [2:0] LT_R = 3'b100;
    localparam logic [2:0] LT_Y = 3'b010;
    localparam logic [2:0] LT_G = 3'b001;

    typedef enum logic [2:0] {
        ST_NS_G = PH_NS_G,
        ST_NS_Y = PH_NS_Y,
        ST_AR1  = PH_AR1,
        ST_EW_G = PH_EW_G,
        ST_EW_Y = PH_EW_Y,
        ST_AR2  = PH_AR2,
        ST_WALK = PH_WALK
    } phase_t;

    // The plain ring NS_G > NS_Y > AR1 > EW_G > EW_Y > AR2 > NS_G.
    // WALK has no fixed successor (it returns to a stored phase), so it
    // and any unused code fall back to NS_G here.
    function automatic logic [2:0] next_phase(input logic [2:0] ph);
        case (ph)
            PH_NS_G: next_phase = PH_NS_Y;
            PH_NS_Y: next_phase = PH_AR1;
            PH_AR1:  next_phase = PH_EW_G;
            PH_EW_G: next_phase = PH_EW_Y;
            PH_EW_Y: next_phase = PH_AR2;
            default: next_phase = PH_NS_G;
        endcase
    endfunction

endpackage

// File: rtl/phase_counter.sv
// phase_counter
//   Per-phase tick counter and latched duration for the phase sequencer.
//   Ports:
//     clk        in   1      rising-edge clock
//     rst        in   1      synchronous active-high reset
//     en         in   1      tick enable
//     dur_next   in   NBITS  duration of the phase being entered (loaded on exit)
//     dur_reset  in   NBITS  duration loaded at reset (the all-red clearance)
//     expire     out  1      current enabled tick is the last one of the phase
module phase_counter #(
    parameter int NBITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NBITS-1:0] dur_next,
    input  logic [NBITS-1:0] dur_reset,
    output logic             expire
);

    logic [NBITS-1:0] cnt;
    logic [NBITS-1:0] dur_q;
    logic [NBITS-1:0] cnt_inc;

    // A zero duration is treated as one tick so the counter never has to
    // wrap all the way round to find a match.
    assign cnt_inc = cnt + NBITS'(1);
    assign expire  = (cnt_inc == dur_q) || (dur_q == '0);

    // On the exit tick the counter restarts and the new phase's duration is
    // captured; between exits the duration inputs are ignored entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            dur_q <= dur_reset;
        end else if (en) begin
            if (expire) begin
                cnt   <= '0;
                dur_q <= dur_next;
            end else begin
                cnt   <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_seq.sv
// traffic_phase_seq
//   Intersection signal-head sequencer: steps through NS_G, NS_Y, AR1, EW_G,
//   EW_Y, AR2 with per-phase durations counted in enabled ticks.
//   Ports:
//     clk, rst           clock and synchronous active-high reset
//     en                 tick enable; nothing advances while low
//     t_green/t_yellow/t_allred   phase durations in en-ticks
//     ns_light, ew_light {R,Y,G} one-hot heads (registered)
//     phase              current phase code (registered)
//     phase_done         one-cycle pulse on the cycle a phase exits
//   Optional macro TRAFFIC_PED_EN adds a pedestrian WALK phase with ports
//     ped_req (in), t_walk (in), walk (out), ped_ack (out).
module traffic_phase_seq
    import traffic_pkg::*;
#(
    parameter int NBITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NBITS-1:0] t_green,
    input  logic [NBITS-1:0] t_yellow,
    input  logic [NBITS-1:0] t_allred,
`ifdef TRAFFIC_PED_EN
    input  logic             ped_req,
    input  logic [NBITS-1:0] t_walk,
    output logic             walk,
    output logic             ped_ack,
`endif
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic [2:0]       phase,
    output logic             phase_done
);

    phase_t           state_q;
    phase_t           state_d;
    logic             expire;
    logic             advance;
    logic [NBITS-1:0] dur_next;
    logic [2:0]       ns_d;
    logic [2:0]       ew_d;
`ifdef TRAFFIC_PED_EN
    phase_t           ret_q;
    logic             ped_pend;
    logic             walk_entry;
`endif

    assign advance = en & expire;
    assign phase   = state_q;

    phase_counter #(
        .NBITS(NBITS)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dur_next (dur_next),
        .dur_reset(t_allred),
        .expire   (expire)
    );

    // Next phase, its duration and its light pattern. Everything is keyed
    // off state_d so the duration and lights of a newly entered phase are
    // captured on the very edge the phase changes.
    always_comb begin
        state_d  = state_q;
        dur_next = t_allred;
        ns_d     = LT_R;
        ew_d     = LT_R;
`ifdef TRAFFIC_PED_EN
        walk_entry = 1'b0;
`endif
        if (advance) begin
            state_d = phase_t'(next_phase(state_q));
`ifdef TRAFFIC_PED_EN
            if (state_q == ST_WALK) begin
                state_d = ret_q;
            end else if (ped_pend && (state_q == ST_AR1 || state_q == ST_AR2)) begin
                state_d    = ST_WALK;
                walk_entry = 1'b1;
            end
`endif
        end
        case (state_d)
            ST_NS_G: begin dur_next = t_green;  ns_d = LT_G; end
            ST_NS_Y: begin dur_next = t_yellow; ns_d = LT_Y; end
            ST_EW_G: begin dur_next = t_green;  ew_d = LT_G; end
            ST_EW_Y: begin dur_next = t_yellow; ew_d = LT_Y; end
`ifdef TRAFFIC_PED_EN
            ST_WALK: dur_next = t_walk;
`endif
            default: ;
        endcase
    end

    // Phase register; reset parks the sequencer in the final all-red so the
    // first phase after reset is always a clearance interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_AR2;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered heads and the exit pulse. Lights only change when the phase
    // does, so with en low they simply reload their current value.
    always_ff @(posedge clk) begin
        if (rst) begin
            ns_light   <= LT_R;
            ew_light   <= LT_R;
            phase_done <= 1'b0;
        end else begin
            ns_light   <= ns_d;
            ew_light   <= ew_d;
            phase_done <= advance;
        end
    end

`ifdef TRAFFIC_PED_EN
    // Pedestrian request latch. A request seen on the WALK entry edge is
    // swallowed by that entry rather than queuing a second walk.
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_pend <= 1'b0;
            ped_ack  <= 1'b0;
            walk     <= 1'b0;
            ret_q    <= ST_NS_G;
        end else begin
            ped_ack <= walk_entry;
            walk    <= (state_d == ST_WALK);
            if (walk_entry) begin
                ped_pend <= 1'b0;
                ret_q    <= phase_t'(next_phase(state_q));
            end else if (ped_req) begin
                ped_pend <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_traffic_phase_seq.sv
// tb_traffic_phase_seq
//   Directed bench for traffic_phase_seq. A countdown model of the phase
//   schedule runs alongside the DUT and is compared every cycle; directed
//   sequences add literal expectations for phase timing.
module tb_traffic_phase_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] t_green;
    logic [15:0] t_yellow;
    logic [15:0] t_allred;
    logic [15:0] t_walk;
    logic        ped_req;
    logic [2:0]  ns_light;
    logic [2:0]  ew_light;
    logic [2:0]  phase;
    logic        phase_done;
`ifdef TRAFFIC_PED_EN
    logic        walk;
    logic        ped_ack;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    int m_phase;
    int m_rem;
    int m_ret;
    int m_nxt;
    bit m_done;
    bit m_pend;
    bit m_ack;
    bit m_walk_entry;
    bit m_valid = 1'b0;

    traffic_phase_seq #(
        .NBITS(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .t_green   (t_green),
        .t_yellow  (t_yellow),
        .t_allred  (t_allred),
`ifdef TRAFFIC_PED_EN
        .ped_req   (ped_req),
        .t_walk    (t_walk),
        .walk      (walk),
        .ped_ack   (ped_ack),
`endif
        .ns_light  (ns_light),
        .ew_light  (ew_light),
        .phase     (phase),
        .phase_done(phase_done)
    );

    always #5 clk = ~clk;

    // Compare one value against its expectation and tally the result.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Drive reset/enable and advance to the next falling edge.
    task automatic applyStimulus(input logic r, input logic e);
        rst = r;
        en  = e;
        @(negedge clk);
    endtask

    // Advance until the DUT shows the target phase, within a cycle budget.
    task automatic waitPhase(input logic [2:0] target, input int budget);
        for (int i = 0; i < budget && phase !== target; i++) @(negedge clk);
        checkOutput("reach_phase", phase, target);
    endtask

    // Count clocks until the DUT leaves phase ph.
    task automatic countPhase(input logic [2:0] ph, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (phase === ph && n < budget);
    endtask

    // Length of a phase in enabled ticks, from the durations on the inputs now.
    function automatic int dur_of(input int ph);
        int t;
        case (ph)
            0, 3:    t = t_green;
            1, 4:    t = t_yellow;
            6:       t = t_walk;
            default: t = t_allred;
        endcase
        return (t == 0) ? 1 : t;
    endfunction

    function automatic logic [2:0] ns_of(input int ph);
        return (ph == 0) ? 3'b001 : (ph == 1) ? 3'b010 : 3'b100;
    endfunction

    function automatic logic [2:0] ew_of(input int ph);
        return (ph == 3) ? 3'b001 : (ph == 4) ? 3'b010 : 3'b100;
    endfunction

    // Reference schedule: each phase holds a countdown of remaining ticks;
    // reaching zero moves to the next phase of the ring (or WALK/return).
    always @(posedge clk) begin
        if (rst) begin
            m_phase = 5;
            m_rem   = dur_of(5);
            m_done  = 1'b0;
            m_pend  = 1'b0;
            m_ack   = 1'b0;
            m_ret   = 0;
            m_valid = 1'b1;
        end else begin
            m_done       = 1'b0;
            m_ack        = 1'b0;
            m_walk_entry = 1'b0;
            if (en) begin
                m_rem--;
                if (m_rem <= 0) begin
                    m_done = 1'b1;
                    m_nxt  = (m_phase + 1) % 6;
`ifdef TRAFFIC_PED_EN
                    if (m_phase == 6) begin
                        m_nxt = m_ret;
                    end else if ((m_phase == 2 || m_phase == 5) && m_pend) begin
                        m_ret        = m_nxt;
                        m_nxt        = 6;
                        m_ack        = 1'b1;
                        m_walk_entry = 1'b1;
                    end
`endif
                    m_phase = m_nxt;
                    m_rem   = dur_of(m_nxt);
                end
            end
            if (m_walk_entry) m_pend = 1'b0;
            else if (ped_req) m_pend = 1'b1;
        end
        #1;
        if (m_valid) begin
            checkOutput("model_phase", phase, m_phase);
            checkOutput("model_ns", ns_light, ns_of(m_phase));
            checkOutput("model_ew", ew_light, ew_of(m_phase));
            checkOutput("model_done", phase_done, m_done);
`ifdef TRAFFIC_PED_EN
            checkOutput("model_walk", walk, m_phase == 6);
            checkOutput("model_ack", ped_ack, m_ack);
`endif
        end
    end

    // Directed sequences with hand-computed timing.
    initial begin
        int n;
        int exp_ph [15] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 4, 4, 5, 0};
        int exp_dn [15] = '{1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 1, 1};
        bit seen_walk;

        t_green  = 16'd4;
        t_yellow = 16'd2;
        t_allred = 16'd1;
        t_walk   = 16'd3;
        ped_req  = 1'b0;

        // Two reset cycles, then check the parked state.
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("reset_phase", phase, 3'd5);
        checkOutput("reset_ns", ns_light, 3'b100);
        checkOutput("reset_ew", ew_light, 3'b100);
        checkOutput("reset_done", phase_done, 1'b0);

        // Nominal 14-cycle schedule: AR2 1, NS_G 4, NS_Y 2, AR1 1, EW_G 4, EW_Y 2.
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("nominal_phase", phase, exp_ph[k]);
            checkOutput("nominal_done", phase_done, exp_dn[k]);
            if (k == 0) begin
                checkOutput("nominal_ns_green", ns_light, 3'b001);
                checkOutput("nominal_ew_red", ew_light, 3'b100);
            end
            if (k == 11) begin
                checkOutput("nominal_ns_red", ns_light, 3'b100);
                checkOutput("nominal_ew_yellow", ew_light, 3'b010);
            end
        end

        // Enable gating: green of 3 with en toggling takes 6 clocks.
        t_green = 16'd3;
        waitPhase(3'd5, 40);
        applyStimulus(1'b0, 1'b1);
        checkOutput("engate_entry", phase, 3'd0);
        en = 1'b0;
        n  = 0;
        do begin
            @(negedge clk);
            n++;
            en = ~en;
        end while (phase === 3'd0 && n < 40);
        checkOutput("engate_clocks", n, 6);
        en = 1'b1;

        // Zero yellow behaves as a single tick.
        waitPhase(3'd3, 100);
        t_yellow = 16'd0;
        waitPhase(3'd1, 100);
        countPhase(3'd1, 100, n);
        checkOutput("zero_yellow_len", n, 1);

        // Mid-phase duration change only affects the next entry.
        t_green = 16'd4;
        waitPhase(3'd0, 100);
        t_green = 16'd9;
        countPhase(3'd0, 100, n);
        checkOutput("midchange_current", n, 4);
        waitPhase(3'd0, 200);
        countPhase(3'd0, 100, n);
        checkOutput("midchange_next", n, 9);

        // Reset in the middle of EW_G: back to AR2 with a fresh count.
        waitPhase(3'd3, 100);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        t_allred = 16'd3;
        applyStimulus(1'b1, 1'b1);
        checkOutput("midreset_phase", phase, 3'd5);
        checkOutput("midreset_ns", ns_light, 3'b100);
        checkOutput("midreset_ew", ew_light, 3'b100);
        checkOutput("midreset_done", phase_done, 1'b0);
        rst = 1'b0;
        countPhase(3'd5, 20, n);
        checkOutput("midreset_ar2_len", n, 3);
        t_allred = 16'd1;

`ifdef TRAFFIC_PED_EN
        // Pedestrian request during NS_G diverts AR1 into a 3-tick WALK.
        waitPhase(3'd0, 100);
        ped_req = 1'b1;
        applyStimulus(1'b0, 1'b1);
        ped_req = 1'b0;
        waitPhase(3'd2, 100);
        countPhase(3'd2, 20, n);
        checkOutput("ped_ar1_len", n, 1);
        checkOutput("ped_walk_phase", phase, 3'd6);
        checkOutput("ped_walk_out", walk, 1'b1);
        checkOutput("ped_ack_pulse", ped_ack, 1'b1);
        countPhase(3'd6, 20, n);
        checkOutput("ped_walk_len", n, 3);
        checkOutput("ped_return_phase", phase, 3'd3);
        checkOutput("ped_ack_cleared", ped_ack, 1'b0);

        // Without a request the WALK phase never appears.
        seen_walk = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (phase === 3'd6) seen_walk = 1'b1;
        end
        checkOutput("ped_no_request", seen_walk, 1'b0);
`else
        seen_walk = 1'b0;
`endif

        // Full-width green: exactly 65535 ticks, no early exit.
        waitPhase(3'd5, 200);
        t_green = 16'hFFFF;
        waitPhase(3'd0, 10);
        countPhase(3'd0, 70000, n);
        checkOutput("max_green_len", n, 65535);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
